// File: rtl/tpu_pkg.sv
// Shared TPU constants: tile dimension and operand/accumulator widths.
// Used by the A/B feeders, tpumac and the array wrapper.
package tpu_pkg;
    localparam int DIM     = 8;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
endpackage

// File: rtl/systolic_a_feeder_if.sv
// Load/advance bus of the A feeder and its skewed column output.
// The master side drives loads and the advance strobe.
interface systolic_a_feeder_if
    import tpu_pkg::*;
#(
    parameter int DW = DIM,
    parameter int BW = BITS_AB
);
    logic                         WrEn;
    logic [$clog2(DW)-1:0]        Arow;
    logic [DW-1:0][BW-1:0]        Ain;
    logic                         en;
    logic [DW-1:0][BW-1:0]        Aout;

    modport master (
        output WrEn, Arow, Ain, en,
        input  Aout
    );

    modport slave (
        input  WrEn, Arow, Ain, en,
        output Aout
    );
endinterface

// File: rtl/systolic_a_feeder_skew_fifo.sv
// One feeder row: parallel-load FIFO draining into a SKEW+1 deep chain.
// A load overrides the FIFO shift, but the chain still captures the old head.
module skew_fifo #(
    parameter int DEPTH = 8,
    parameter int SKEW  = 0,
    parameter int W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld,
    input  logic                    en,
    input  logic [DEPTH-1:0][W-1:0] din,
    output logic [W-1:0]            dout
);
    logic [DEPTH-1:0][W-1:0] fifo;
    logic [SKEW:0][W-1:0]    skw;

    // Row storage: load wins, otherwise shift toward head with zero fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo <= '0;
        end else if (ld) begin
            fifo <= din;
        end else if (en) begin
            fifo <= {W'(0), fifo[DEPTH-1:1]};
        end
    end

    // Skew chain: captures the pre-edge head on every enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skw <= '0;
        end else if (en) begin
            skw[0] <= fifo[0];
            for (int k = 1; k <= SKEW; k++) begin
                skw[k] <= skw[k-1];
            end
        end
    end

    assign dout = skw[SKEW];
endmodule

// File: rtl/systolic_a_feeder.sv
// A-operand feeder: decodes the load row and fans out to DIM skewed rows.
// Row r is delayed r enabled edges relative to row 0.
module systolic_a_feeder
    import tpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    systolic_a_feeder_if.slave bus
);
    logic [DIM-1:0] ld;

    // One-hot row select for the parallel load.
    always_comb begin
        ld = '0;
        if (bus.WrEn) begin
            ld[bus.Arow] = 1'b1;
        end
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        skew_fifo #(
            .DEPTH (DIM),
            .SKEW  (r),
            .W     (BITS_AB)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (ld[r]),
            .en    (bus.en),
            .din   (bus.Ain),
            .dout  (bus.Aout[r])
        );
    end
endmodule

// File: tb/tb_systolic_a_feeder.sv
// Bench for systolic_a_feeder: table checkpoints, hand sequences,
// and random traffic against a queue-based stream model.
module tb_systolic_a_feeder;
    import tpu_pkg::*;

    typedef logic [DIM-1:0][BITS_AB-1:0] vec_t;

    typedef struct {
        int          k;
        int          r;
        logic [7:0]  exp;
    } chk_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    systolic_a_feeder_if ifc ();

    systolic_a_feeder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per-row queue of pending values and log of emitted heads.
    logic [7:0] mq   [DIM][$];
    logic [7:0] outs [DIM][$];

    function automatic vec_t model_out();
        vec_t v;
        v = '0;
        for (int r = 0; r < DIM; r++) begin
            if (outs[r].size() > r)
                v[r] = outs[r][outs[r].size()-1-r];
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < DIM; r++) begin
            mq[r].delete();
            outs[r].delete();
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive at negedge, clock once, update model, compare at next negedge.
    task automatic step(input logic we, input int row,
                        input vec_t din, input logic e);
        ifc.WrEn = we;
        ifc.Arow = row[$clog2(DIM)-1:0];
        ifc.Ain  = din;
        ifc.en   = e;
        @(posedge clk);
        for (int r = 0; r < DIM; r++) begin
            if (e) begin
                outs[r].push_back(mq[r].size() > 0 ? mq[r][0] : 8'h00);
                if (mq[r].size() > 0 && !(we && row == r))
                    void'(mq[r].pop_front());
            end
        end
        if (we) begin
            mq[row].delete();
            for (int c = 0; c < DIM; c++) mq[row].push_back(din[c]);
        end
        @(negedge clk);
        chk("model", ifc.Aout, model_out());
    endtask

    task automatic load_tile();
        vec_t d;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) d[c] = 8'(16*r + c);
            step(1'b1, r, d, 1'b0);
        end
    endtask

    chk_t tbl[$];
    vec_t drain_rec[17];
    vec_t d;
    vec_t hold;
    int   k;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tbl = '{
            '{1, 0, 8'h00}, '{1, 1, 8'h00}, '{1, 7, 8'h00},
            '{2, 0, 8'h01}, '{2, 1, 8'h10}, '{8, 0, 8'h07},
            '{8, 3, 8'h34}, '{8, 7, 8'h70}, '{9, 0, 8'h00},
            '{15, 7, 8'h77}, '{15, 6, 8'h00}, '{15, 0, 8'h00},
            '{16, 7, 8'h00}
        };
        rst_n    = 1'b0;
        ifc.WrEn = 1'b0;
        ifc.Arow = '0;
        ifc.Ain  = '0;
        ifc.en   = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("reset_state", ifc.Aout, 64'h0);
        rst_n = 1'b1;

        // Full tile drain with table checkpoints.
        load_tile();
        for (int e = 1; e <= 16; e++) begin
            step(1'b0, 0, '0, 1'b1);
            drain_rec[e] = ifc.Aout;
            foreach (tbl[i]) begin
                if (tbl[i].k == e)
                    chk($sformatf("drain_k%0d_r%0d", e, tbl[i].r),
                        64'(ifc.Aout[tbl[i].r]), 64'(tbl[i].exp));
            end
        end
        chk("drain_k16_all", drain_rec[16], 64'h0);

        // en pulsed every third cycle: same per-edge sequence, stable between.
        load_tile();
        for (int e = 1; e <= 16; e++) begin
            step(1'b0, 0, '0, 1'b1);
            chk($sformatf("gap_k%0d", e), ifc.Aout, drain_rec[e]);
            hold = ifc.Aout;
            step(1'b0, 0, '0, 1'b0);
            step(1'b0, 0, '0, 1'b0);
            chk($sformatf("gap_hold%0d", e), ifc.Aout, hold);
        end

        // Reload row 2 at enabled edge 3.
        load_tile();
        for (int e = 1; e <= 16; e++) begin
            if (e == 3) step(1'b1, 2, {DIM{8'h55}}, 1'b1);
            else        step(1'b0, 0, '0, 1'b1);
            if (e == 5)  chk("ld_r2_old", 64'(ifc.Aout[2]), 64'h22);
            if (e == 6)  chk("ld_r2_new", 64'(ifc.Aout[2]), 64'h55);
            if (e == 13) chk("ld_r2_last", 64'(ifc.Aout[2]), 64'h55);
            if (e == 14) chk("ld_r2_end", 64'(ifc.Aout[2]), 64'h00);
            if (e == 8)  chk("ld_r7_undist", 64'(ifc.Aout[7]), 64'h70);
        end

        // Signed pass-through on row 0.
        d = '0;
        d[0] = 8'h80;
        d[1] = 8'hFF;
        d[2] = 8'h7F;
        step(1'b1, 0, d, 1'b0);
        step(1'b0, 0, '0, 1'b1);
        chk("sgn_m128", 64'($signed(ifc.Aout[0])), 64'(-128));
        step(1'b0, 0, '0, 1'b1);
        chk("sgn_m1", 64'($signed(ifc.Aout[0])), 64'(-1));
        step(1'b0, 0, '0, 1'b1);
        chk("sgn_p127", 64'($signed(ifc.Aout[0])), 64'(127));

        // Random loads and en against the model.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < DIM; c++) d[c] = 8'($urandom);
            step(($urandom_range(0, 3) == 0), $urandom_range(0, DIM-1),
                 d, $urandom_range(0, 1) == 1);
        end

        // Async reset mid-cycle with data in flight.
        load_tile();
        for (int e = 0; e < 4; e++) step(1'b0, 0, '0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", ifc.Aout, 64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int e = 0; e < 16; e++) begin
            step(1'b0, 0, '0, 1'b1);
            if (ifc.Aout !== '0) k++;
        end
        chk("rst_drain_zero", 64'(k), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_a_feeder.md
# systolic_a_feeder

Upstream feeder for the tpumac systolic array. It holds one DIM×DIM tile of signed 8-bit A operands, loaded one row per cycle. It streams the tile into the array's left edge as a diagonally skewed column vector: row r is delayed r cycles relative to row 0. Each Aout[r] connects directly to the Ain of the first tpumac in array row r.

## Interface
- DIM, 8, tile dimension; power of two, ≥2
- BITS_AB, 8, operand width; signed, passed through unmodified
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- WrEn  input  1  load row Arow from Ain this cycle
- Arow  input  $clog2(DIM)  row index for load
- Ain  input  DIM×BITS_AB  row data, packed [DIM-1:0][BITS_AB-1:0]; element c is column c
- en  input  1  advance: shift all FIFOs and skew chains one step
- Aout  output  DIM×BITS_AB  skewed column, packed [DIM-1:0][BITS_AB-1:0]; element r drives array row r

## Operation
- Storage: DIM row FIFOs, fifo[r][0..DIM-1], with head at index 0. Each row has a skew chain of r+1 registers, skw[r][0..r]. Aout[r] = skw[r][r].
- Load: WrEn=1 sets fifo[Arow][c] ← Ain[c] for all c in one edge. Other rows are unaffected. Loading is independent of en.
- Shift: en=1 on an edge makes every FIFO not being loaded shift toward the head: fifo[r][c] ← fifo[r][c+1], with tail ← 0. Every chain shifts: skw[r][0] ← fifo[r][0] (pre-edge value) and skw[r][k] ← skw[r][k-1].
- en=0: FIFOs and chains hold; Aout holds.
- Simultaneous WrEn and en: for row Arow, the load wins over the FIFO shift. That row's chain still shifts and captures the old head. All other rows shift normally.
- Drain: after a full tile load, exactly 2·DIM−1 enabled edges move the last element of row DIM−1 to Aout. Zeros follow afterwards, so the array sees zero operands (no MAC contribution).
- Reloading mid-stream is legal. The new row data enters behind whatever is already in that row's chain.
- No arithmetic; data is carried bit-exact (signed, no extension).

## Timing
- Reset (async assert, sync-safe deassert): all fifo and skw registers are 0, so Aout = all zeros immediately on rst_n=0.
- Reset mid-stream discards all state; there is no partial drain.
- Load latency: the row is visible at the FIFO head the edge after WrEn, and on Aout only after en edges.
- Skew timing: counting enabled edges k=1,2,… after the tile is loaded, after edge k Aout[r] = A[r][k−1−r] when 0 ≤ k−1−r < DIM, and 0 otherwise.
- Aout is fully registered, with no combinational path from any input to Aout.
- Throughput: one column per enabled cycle. en may toggle arbitrarily; skew is kept in enabled-edge units.

## Structure
- Shared package tpu_pkg holds the DIM, BITS_AB and BITS_C (16) constants, shared with tpumac and the array wrapper.
- One sub-module, skew_fifo, implements one row:
  - parameters DEPTH and SKEW;
  - parallel load plus shift, with the skew chain internal;
  - instantiated DIM times via generate, with SKEW=r.
- Top level does Arow decode and the packing/unpacking of Ain and Aout only.

## Test plan
- Reset: drive rst_n=0 mid-cycle with the FIFOs holding nonzero data. Aout = 0 immediately and remains 0 after release with en=1 and no loads.
- Skew drain (DIM=8): load A[r][c] = 16·r + c for rows 0..7, then hold en=1 for 15 edges.
  - After edge 1: Aout = {0,…,0,0x00}.
  - After edge 8: Aout[0]=0x07, Aout[7]=0x70.
  - After edge 15: Aout[7]=0x77, all others 0.
  - Edge 16: all zeros.
- en gaps: same tile with en pulsed every third cycle. Aout sequence per enabled edge is identical to the skew-drain case, and Aout is stable between pulses.
- Load during en: while streaming, at enabled edge 3 assert WrEn with Arow=2 and Ain = all 0x55.
  - Aout[2] continues with its old head value, then emits 0x55 ×8 after the remaining chain contents.
  - Other rows are undisturbed.
- Signed pass-through: load row 0 with 0x80, 0xFF, 0x7F. Aout[0] shows exactly −128, −1, 127 on edges 1–3.
- Integration: feed a 2×2 tpumac array from the feeder plus a matching B feeder with random signed tiles. Cout matches the reference matrix product after 3·DIM−2 enabled cycles.
